// File: rtl/mem_pkg.sv
// Shared definitions for the two-requester DataMemory arbiter: default widths,
// FSM state encoding and requester IDs.
package mem_pkg;

  localparam int unsigned DefWidth     = 32;
  localparam int unsigned DefAddrWidth = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RESP = 2'd2
  } arbStateT;

  localparam logic ReqId0 = 1'b0;
  localparam logic ReqId1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester wins; on a tie the requester
// that was not granted last wins. Output is one-hot or zero.
module rr_arbiter2
  import mem_pkg::*;
(
  input  logic [1:0] reqValid,
  input  logic       lastGrant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (reqValid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (lastGrant == ReqId1) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto a single-port synchronous DataMemory,
// one transaction in flight at a time (IDLE -> CMD [-> RESP]).
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned Width     = DefWidth,
  parameter int unsigned AddrWidth = DefAddrWidth
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_valid,
  input  logic [1:0]             req_write,
  input  logic [2*AddrWidth-1:0] req_addr,
  input  logic [2*Width-1:0]     req_wdata,
  output logic [1:0]             req_ready,
  output logic [1:0]             rsp_valid,
  output logic [Width-1:0]       rsp_rdata,
  output logic                   MemWrite,
  output logic                   MemRead,
  output logic [AddrWidth-1:0]   Addr,
  output logic [Width-1:0]       WrData,
  input  logic [Width-1:0]       ReadData
);

  arbStateT             state;
  arbStateT             stateNext;
  logic                 lastGrant;
  logic [1:0]           grant;
  logic                 accept;
  logic                 acceptId;
  logic                 opWrite;
  logic                 idLat;
  logic [AddrWidth-1:0] addrLat;
  logic [Width-1:0]     wdataLat;
  logic [Width-1:0]     rdataHold;

  rr_arbiter2 uArb (
    .reqValid  (req_valid),
    .lastGrant (lastGrant),
    .grant     (grant)
  );

  assign acceptId = grant[1] ? ReqId1 : ReqId0;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Strobes and handshakes are forced low while rst is high so a reset
  // landing in CMD or RESP never leaks a command or response.
  always_comb begin
    stateNext = state;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    MemWrite  = 1'b0;
    MemRead   = 1'b0;
    accept    = 1'b0;
    rsp_rdata = rdataHold;
    unique case (state)
      IDLE: begin
        req_ready = grant;
        accept    = |grant;
        if (accept) stateNext = CMD;
      end
      CMD: begin
        MemWrite  = opWrite;
        MemRead   = !opWrite;
        stateNext = opWrite ? IDLE : RESP;
      end
      RESP: begin
        rsp_valid[idLat] = 1'b1;
        rsp_rdata        = ReadData;
        stateNext        = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    if (rst) begin
      req_ready = 2'b00;
      rsp_valid = 2'b00;
      MemWrite  = 1'b0;
      MemRead   = 1'b0;
      accept    = 1'b0;
      rsp_rdata = '0;
    end
  end

  // Transaction latch and round-robin history, updated only on a handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      lastGrant <= ReqId1;
      idLat     <= ReqId0;
      opWrite   <= 1'b0;
      addrLat   <= '0;
      wdataLat  <= '0;
    end else if (accept) begin
      lastGrant <= acceptId;
      idLat     <= acceptId;
      opWrite   <= req_write[acceptId];
      addrLat   <= acceptId ? req_addr[AddrWidth +: AddrWidth] : req_addr[0 +: AddrWidth];
      wdataLat  <= acceptId ? req_wdata[Width +: Width] : req_wdata[0 +: Width];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                rdataHold <= '0;
    else if (state == RESP) rdataHold <= ReadData;
  end

  assign Addr   = rst ? '0 : addrLat;
  assign WrData = rst ? '0 : wdataLat;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, reset corner sequences and a
// randomized run against a cycle-timeline transaction model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [15:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        MemWrite;
  logic        MemRead;
  logic [7:0]  Addr;
  logic [31:0] WrData;
  logic [31:0] ReadData;

  mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .Addr      (Addr),
    .WrData    (WrData),
    .ReadData  (ReadData)
  );

  always #5 clk = ~clk;

  // Synchronous DataMemory: preloaded with a recognisable pattern on the first edge.
  logic [31:0] mem [256];
  bit          memInit;
  always @(posedge clk) begin
    if (!memInit) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE0000 | 32'(i);
      memInit <= 1'b1;
    end else if (MemWrite) begin
      mem[Addr] <= WrData;
    end
    if (rst)          ReadData <= '0;
    else if (MemRead) ReadData <= mem[Addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] v, input logic [1:0] w,
                       input logic [7:0] a0, input logic [7:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
    @(negedge clk);
    rst       = r;
    req_valid = v;
    req_write = w;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
    #1;
  endtask

  typedef struct {
    logic [1:0]  v;
    logic [1:0]  w;
    logic [7:0]  a0;
    logic [7:0]  a1;
    logic [31:0] d0;
    logic [1:0]  ready;
    logic        mw;
    logic        mr;
    logic [7:0]  addr;
    logic [31:0] wd;
    logic [1:0]  rv;
    logic [31:0] rdata;
  } vecT;

  function automatic vecT mk(logic [1:0] v, logic [1:0] w, logic [7:0] a0, logic [7:0] a1,
                             logic [31:0] d0, logic [1:0] ready, logic mw, logic mr,
                             logic [7:0] addr, logic [31:0] wd, logic [1:0] rv,
                             logic [31:0] rdata);
    vecT x;
    x.v = v; x.w = w; x.a0 = a0; x.a1 = a1; x.d0 = d0;
    x.ready = ready; x.mw = mw; x.mr = mr; x.addr = addr; x.wd = wd;
    x.rv = rv; x.rdata = rdata;
    return x;
  endfunction

  task automatic chkAllZero(input string tag);
    chk({tag, ".ready"}, 32'(req_ready), 32'd0);
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".MemWrite"}, 32'(MemWrite), 32'd0);
    chk({tag, ".MemRead"}, 32'(MemRead), 32'd0);
    chk({tag, ".Addr"}, 32'(Addr), 32'd0);
    chk({tag, ".WrData"}, WrData, 32'd0);
    chk({tag, ".rsp_rdata"}, rsp_rdata, 32'd0);
  endtask

  vecT         vecs [27];
  logic [31:0] shadow [256];

  initial begin
    rst = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;

    // Reset held for two cycles while requester 0 is already asking.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 2'b01, 2'b01, 8'h10, 8'h00, 32'hAAAAAAAA, 32'h0);
      chkAllZero("reset");
    end

    // Directed table: first row is the first cycle out of reset.
    vecs[0]  = mk(2'b01, 2'b01, 8'h10, 8'h00, 32'hAAAAAAAA, 2'b01, 0, 0, 8'h00, 32'h0, 2'b00, 32'h0);
    vecs[1]  = mk(2'b01, 2'b00, 8'h10, 8'h00, 32'h0,        2'b00, 1, 0, 8'h10, 32'hAAAAAAAA, 2'b00, 32'h0);
    vecs[2]  = mk(2'b01, 2'b00, 8'h10, 8'h00, 32'h0,        2'b01, 0, 0, 8'h00, 32'h0, 2'b00, 32'h0);
    vecs[3]  = mk(2'b00, 2'b00, 8'h00, 8'h00, 32'h0,        2'b00, 0, 1, 8'h10, 32'h0, 2'b00, 32'h0);
    vecs[4]  = mk(2'b00, 2'b00, 8'h00, 8'h00, 32'h0,        2'b00, 0, 0, 8'h00, 32'h0, 2'b01, 32'hAAAAAAAA);
    vecs[5]  = mk(2'b11, 2'b00, 8'h01, 8'h02, 32'h0,        2'b10, 0, 0, 8'h00, 32'h0, 2'b00, 32'h0);
    vecs[6]  = mk(2'b11, 2'b00, 8'h01, 8'h02, 32'h0,        2'b00, 0, 1, 8'h02, 32'h0, 2'b00, 32'h0);
    vecs[7]  = mk(2'b11, 2'b00, 8'h01, 8'h02, 32'h0,        2'b00, 0, 0, 8'h00, 32'h0, 2'b10, 32'hC0DE0002);
    vecs[8]  = mk(2'b11, 2'b00, 8'h01, 8'h02, 32'h0,        2'b01, 0, 0, 8'h00, 32'h0, 2'b00, 32'h0);
    vecs[9]  = mk(2'b11, 2'b00, 8'h01, 8'h02, 32'h0,        2'b00, 0, 1, 8'h01, 32'h0, 2'b00, 32'h0);
    vecs[10] = mk(2'b11, 2'b00, 8'h01, 8'h02, 32'h0,        2'b00, 0, 0, 8'h00, 32'h0, 2'b01, 32'hC0DE0001);
    vecs[11] = mk(2'b11, 2'b00, 8'h01, 8'h02, 32'h0,        2'b10, 0, 0, 8'h00, 32'h0, 2'b00, 32'h0);
    vecs[12] = mk(2'b11, 2'b00, 8'h01, 8'h02, 32'h0,        2'b00, 0, 1, 8'h02, 32'h0, 2'b00, 32'h0);
    vecs[13] = mk(2'b11, 2'b00, 8'h01, 8'h02, 32'h0,        2'b00, 0, 0, 8'h00, 32'h0, 2'b10, 32'hC0DE0002);
    vecs[14] = mk(2'b10, 2'b00, 8'h00, 8'hFF, 32'h0,        2'b10, 0, 0, 8'h00, 32'h0, 2'b00, 32'h0);
    vecs[15] = mk(2'b01, 2'b01, 8'h05, 8'hFF, 32'h12345678, 2'b00, 0, 1, 8'hFF, 32'h0, 2'b00, 32'h0);
    vecs[16] = mk(2'b01, 2'b01, 8'h05, 8'hFF, 32'h12345678, 2'b00, 0, 0, 8'h00, 32'h0, 2'b10, 32'hC0DE00FF);
    vecs[17] = mk(2'b01, 2'b01, 8'h05, 8'hFF, 32'h12345678, 2'b01, 0, 0, 8'h00, 32'h0, 2'b00, 32'h0);
    vecs[18] = mk(2'b10, 2'b00, 8'h05, 8'h02, 32'h0,        2'b00, 1, 0, 8'h05, 32'h12345678, 2'b00, 32'h0);
    vecs[19] = mk(2'b00, 2'b00, 8'h00, 8'h00, 32'h0,        2'b00, 0, 0, 8'h00, 32'h0, 2'b00, 32'h0);
    vecs[20] = mk(2'b11, 2'b00, 8'h05, 8'h02, 32'h0,        2'b10, 0, 0, 8'h00, 32'h0, 2'b00, 32'h0);
    vecs[21] = mk(2'b00, 2'b00, 8'h00, 8'h00, 32'h0,        2'b00, 0, 1, 8'h02, 32'h0, 2'b00, 32'h0);
    vecs[22] = mk(2'b00, 2'b00, 8'h00, 8'h00, 32'h0,        2'b00, 0, 0, 8'h00, 32'h0, 2'b10, 32'hC0DE0002);
    vecs[23] = mk(2'b01, 2'b00, 8'h05, 8'h00, 32'h0,        2'b01, 0, 0, 8'h00, 32'h0, 2'b00, 32'h0);
    vecs[24] = mk(2'b00, 2'b00, 8'h00, 8'h00, 32'h0,        2'b00, 0, 1, 8'h05, 32'h0, 2'b00, 32'h0);
    vecs[25] = mk(2'b00, 2'b00, 8'h00, 8'h00, 32'h0,        2'b00, 0, 0, 8'h00, 32'h0, 2'b01, 32'h12345678);
    vecs[26] = mk(2'b00, 2'b00, 8'h00, 8'h00, 32'h0,        2'b00, 0, 0, 8'h00, 32'h0, 2'b00, 32'h0);

    for (int i = 0; i < 27; i++) begin
      drive(1'b0, vecs[i].v, vecs[i].w, vecs[i].a0, vecs[i].a1, vecs[i].d0, 32'h0);
      chk($sformatf("vec%0d.ready", i), 32'(req_ready), 32'(vecs[i].ready));
      chk($sformatf("vec%0d.MemWrite", i), 32'(MemWrite), 32'(vecs[i].mw));
      chk($sformatf("vec%0d.MemRead", i), 32'(MemRead), 32'(vecs[i].mr));
      chk($sformatf("vec%0d.rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].rv));
      if (vecs[i].mw || vecs[i].mr) chk($sformatf("vec%0d.Addr", i), 32'(Addr), 32'(vecs[i].addr));
      if (vecs[i].mw) chk($sformatf("vec%0d.WrData", i), WrData, vecs[i].wd);
      if (vecs[i].rv != 2'b00) chk($sformatf("vec%0d.rsp_rdata", i), rsp_rdata, vecs[i].rdata);
    end

    // Reset landing in the CMD cycle of a read aborts it completely.
    drive(1'b0, 2'b01, 2'b00, 8'h10, 8'h00, 32'h0, 32'h0);
    chk("abort.accept", 32'(req_ready), 32'd1);
    drive(1'b1, 2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
    chkAllZero("abort.cmd");
    drive(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
    chk("abort.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort.MemRead", 32'(MemRead), 32'd0);
    drive(1'b0, 2'b01, 2'b00, 8'h10, 8'h00, 32'h0, 32'h0);
    chk("after.ready", 32'(req_ready), 32'd1);
    drive(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
    chk("after.MemRead", 32'(MemRead), 32'd1);
    chk("after.Addr", 32'(Addr), 32'h10);
    drive(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
    chk("after.rsp_valid", 32'(rsp_valid), 32'd1);
    chk("after.rsp_rdata", rsp_rdata, 32'hAAAAAAAA);

    // Randomized run against a timeline model: the bus is free from cycle
    // freeAt on; a write holds it 2 cycles, a read 3; command one cycle after
    // accept, read data two cycles after accept.
    begin
      int          lastG, freeAt, k, rspId, cmdT, rspT;
      bit          cmdPend, rspPend, cmdW;
      logic [7:0]  cmdA, a0, a1;
      logic [31:0] cmdD, rspD, d0, d1;
      logic [1:0]  v, w, expReady, expRv;

      drive(1'b1, 2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
      for (int i = 0; i < 256; i++) shadow[i] = mem[i];
      lastG = 1; freeAt = 0; cmdPend = 0; rspPend = 0;
      cmdT = 0; rspT = 0; cmdW = 0; rspId = 0; cmdA = '0; cmdD = '0; rspD = '0;

      for (int t = 0; t < 800; t++) begin
        v  = 2'($urandom_range(0, 3));
        w  = 2'($urandom_range(0, 3));
        a0 = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
        a1 = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
        d0 = $urandom;
        d1 = $urandom;
        drive(1'b0, v, w, a0, a1, d0, d1);

        k = -1;
        if (t >= freeAt) begin
          if (v == 2'b11)      k = (lastG == 0) ? 1 : 0;
          else if (v == 2'b01) k = 0;
          else if (v == 2'b10) k = 1;
        end
        expReady = (k == 0) ? 2'b01 : (k == 1) ? 2'b10 : 2'b00;
        expRv    = (rspPend && rspT == t) ? ((rspId == 0) ? 2'b01 : 2'b10) : 2'b00;

        chk("rnd.ready", 32'(req_ready), 32'(expReady));
        chk("rnd.MemWrite", 32'(MemWrite), 32'(cmdPend && cmdT == t && cmdW));
        chk("rnd.MemRead", 32'(MemRead), 32'(cmdPend && cmdT == t && !cmdW));
        if (cmdPend && cmdT == t) chk("rnd.Addr", 32'(Addr), 32'(cmdA));
        if (cmdPend && cmdT == t && cmdW) chk("rnd.WrData", WrData, cmdD);
        chk("rnd.rsp_valid", 32'(rsp_valid), 32'(expRv));
        if (expRv != 2'b00) chk("rnd.rsp_rdata", rsp_rdata, rspD);

        if (cmdPend && cmdT == t) cmdPend = 0;
        if (rspPend && rspT == t) rspPend = 0;
        if (k >= 0) begin
          lastG   = k;
          cmdPend = 1;
          cmdT    = t + 1;
          cmdW    = w[k];
          cmdA    = (k == 1) ? a1 : a0;
          cmdD    = (k == 1) ? d1 : d0;
          if (cmdW) begin
            shadow[cmdA] = cmdD;
            freeAt = t + 2;
          end else begin
            rspPend = 1;
            rspT    = t + 2;
            rspId   = k;
            rspD    = shadow[cmdA];
            freeAt  = t + 3;
          end
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
